// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard and forwarding scoreboard for the in-order pipeline
// Optional stall/forward statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_wr,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic [31:0]           stall_count,
  output logic [31:0]           fwd_count
);

  logic [DEPTH:1]          v_q,  v_d;
  logic [DEPTH:1]          ld_q, ld_d;
  logic [REG_ADDR_W-1:0]   rd_q [1:DEPTH];
  logic [REG_ADDR_W-1:0]   rd_d [1:DEPTH];

  logic                    hz1, hz2;
  logic                    push;

  // Walk from the oldest entry to the youngest so the youngest matching writer wins,
  // and its load flag alone decides whether the operand is still unavailable.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    hz1      = 1'b0;
    hz2      = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rs1_used && (rs1 != '0) && v_q[k] && (rd_q[k] == rs1)) begin
        fwd_sel1 = SEL_W'(k);
        hz1      = ld_q[k] && (k <= LOAD_LAT);
      end
      if (rs2_used && (rs2 != '0) && v_q[k] && (rd_q[k] == rs2)) begin
        fwd_sel2 = SEL_W'(k);
        hz2      = ld_q[k] && (k <= LOAD_LAT);
      end
    end
  end

  assign stall = issue_valid && !flush && (hz1 || hz2);
  assign push  = issue_valid && issue_wr && (issue_rd != '0) && !stall && !flush;

  always_comb begin
    v_d     = {v_q[DEPTH-1:1], push};
    ld_d    = {ld_q[DEPTH-1:1], push && issue_load};
    rd_d[1] = push ? issue_rd : '0;
    for (int k = 2; k <= DEPTH; k++) begin
      rd_d[k] = rd_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q,   fwd_cnt_d;
  logic [31:0] fwd_inc;

  always_comb begin
    fwd_inc = 32'd0;
    if (issue_valid && !stall && !flush) begin
      fwd_inc = 32'(fwd_sel1 != '0) + 32'(fwd_sel2 != '0);
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // Saturate instead of wrapping when the increment would overflow.
    if (fwd_cnt_q > (32'hFFFF_FFFF - fwd_inc)) begin
      fwd_cnt_d = 32'hFFFF_FFFF;
    end else begin
      fwd_cnt_d = fwd_cnt_q + fwd_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign fwd_count   = fwd_cnt_q;
`else
  assign stall_count = 32'd0;
  assign fwd_count   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=1)
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_wr;
  logic       issue_load;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;
  logic       flush;
  logic       stall;
  logic [2:0] fwd_sel1, fwd_sel2;
  logic [31:0] stall_count, fwd_count;

  int errors = 0;
  int checks = 0;
  int vec_no = 0;

  logic [6:0] exp_q [$];
  int         id_q  [$];

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_load(issue_load),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
    .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_count(stall_count), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  // One ID-stage instruction per call; the expected {stall, sel1, sel2} goes to the scoreboard.
  task automatic step(input logic [4:0] rd, input logic wr, input logic ld,
                      input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                      input logic fl, input logic es, input logic [2:0] e1, input logic [2:0] e2);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_wr    = wr;
    issue_load  = ld;
    rs1         = a;
    rs1_used    = ua;
    rs2         = b;
    rs2_used    = ub;
    flush       = fl;
    vec_no++;
    exp_q.push_back({es, e1, e2});
    id_q.push_back(vec_no);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      issue_wr    = 1'b0;
      issue_load  = 1'b0;
      rs1_used    = 1'b0;
      rs2_used    = 1'b0;
      flush       = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst && issue_valid) begin
      logic [6:0] e;
      int id;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: output present but no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        if ({stall, fwd_sel1, fwd_sel2} !== e) begin
          errors++;
          $display("FAIL vec%0d stall/sel1/sel2: got %b/%0d/%0d expected %b/%0d/%0d",
                   id, stall, fwd_sel1, fwd_sel2, e[6], e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_sc, exp_fc;
    rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_wr = 1'b0; issue_load = 1'b0;
    rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // reset state: reader of x5 sees nothing
    step(5'd0, 0, 0, 5'd5, 1, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    // lw x7 then dependent add x8,x7,x7: one stall cycle, then forward from MEM
    step(5'd7, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd8, 1, 0, 5'd7, 1, 5'd7, 1, 0, 1, 3'd1, 3'd1);
    step(5'd8, 1, 0, 5'd7, 1, 5'd7, 1, 0, 0, 3'd2, 3'd2);
    idle(3);
    // add x3 then sub reading x3 (EX forward), then reader of x3 (MEM forward)
    step(5'd3, 1, 0, 5'd1, 1, 5'd2, 1, 0, 0, 3'd0, 3'd0);
    step(5'd9, 1, 0, 5'd3, 1, 5'd0, 0, 0, 0, 3'd1, 3'd0);
    step(5'd0, 0, 0, 5'd4, 1, 5'd3, 1, 0, 0, 3'd0, 3'd2);
    idle(1);
`ifdef HAZARD_STATS_EN
    exp_sc = 32'd1;
    exp_fc = 32'd4;
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    checks++;
    if (stall_count !== exp_sc) begin
      errors++;
      $display("FAIL stall_count: got %0d expected %0d", stall_count, exp_sc);
    end
    checks++;
    if (fwd_count !== exp_fc) begin
      errors++;
      $display("FAIL fwd_count: got %0d expected %0d", fwd_count, exp_fc);
    end
    idle(2);
    // oldest tracked stage (WB) forwards, then the writer retires
    step(5'd12, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    idle(2);
    step(5'd0, 0, 0, 5'd12, 1, 5'd0, 0, 0, 0, 3'd3, 3'd0);
    step(5'd0, 0, 0, 5'd12, 1, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    idle(3);
    // back-to-back writers of x4: youngest wins; x0 never matches
    step(5'd4, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd4, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd0, 0, 0, 5'd4, 1, 5'd4, 1, 0, 0, 3'd1, 3'd1);
    step(5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd0, 0, 0, 5'd0, 1, 5'd4, 1, 0, 0, 3'd0, 3'd3);
    idle(3);
    // flush beats the load-use hazard and the flushed writer of x10 becomes a bubble
    step(5'd9, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd10, 1, 0, 5'd9, 1, 5'd0, 0, 1, 0, 3'd1, 3'd0);
    step(5'd0, 0, 0, 5'd10, 1, 5'd9, 1, 0, 0, 3'd0, 3'd2);
    idle(3);
    // younger ALU writer of x11 hides the older load; unused rs1 never forwards
    step(5'd11, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd11, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd0, 0, 0, 5'd11, 1, 5'd0, 0, 0, 0, 3'd1, 3'd0);
    step(5'd0, 0, 0, 5'd11, 0, 5'd11, 1, 0, 0, 3'd0, 3'd2);
    idle(3);
    // load-use on rs2 alone
    step(5'd13, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    step(5'd0, 0, 0, 5'd1, 1, 5'd13, 1, 0, 1, 3'd0, 3'd1);
    step(5'd0, 0, 0, 5'd1, 1, 5'd13, 1, 0, 0, 3'd0, 3'd2);
    idle(3);
    // reset mid-operation drops the in-flight load
    step(5'd7, 1, 1, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue_valid = 1'b0;
    step(5'd0, 0, 0, 5'd7, 1, 5'd7, 1, 0, 0, 3'd0, 3'd0);
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
